regfile_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/scrub_ctrl.sv | 76 +++++++
 rtl/regfile_param.sv | 133 +++++++++++++
 tb/tb_regfile_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the parametrised register file and its scrub
// controller: the two-state encoding of the scrub sequencer.
package regfile_pkg;

    // Scrub sequencer states. IDLE serves reads and writes normally;
    // SCRUB clears one entry per clock and blocks writes.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } scrub_state_e;

endpackage

// File: rtl/scrub_ctrl.sv
// scrub_ctrl
// Sequencer that walks an index over 0..DEPTH-1, one entry per clock, so the
// register file can clear every entry. A level-sampled request starts a pass.
// A request that arrives during a pass is ignored rather than queued.
//
// Ports:
//   clk        in   rising-edge clock
//   clr_n      in   asynchronous active-low reset
//   scrub_req  in   start a pass (sampled only while idle)
//   busy       out  a pass is in progress
//   scrub_done out  high during the final cycle of a pass
//   scrub_we   out  clear entry scrub_idx at the next edge
//   scrub_idx  out  entry being cleared at the next edge
module scrub_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          scrub_req,
    output logic          busy,
    output logic          scrub_done,
    output logic          scrub_we,
    output logic [AW-1:0] scrub_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    scrub_state_e  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // The index stops at DEPTH-1 and is reloaded with zero, so a DEPTH that
    // is not a power of two never lets it address a missing entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (scrub_req) begin
                    state_d = ST_SCRUB;
                    idx_d   = '0;
                end
            end
            ST_SCRUB: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy       = (state_q == ST_SCRUB);
    assign scrub_done = busy && (idx_q == LAST_IDX);
    assign scrub_we   = busy;
    assign scrub_idx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param
// DEPTH x WIDTH flop-based register file with one write port and two
// registered read ports. Reads see a same-edge write (write-first bypass)
// and a same-edge scrub clear. Entry 0 can be hard-wired to zero.
//
// Ports:
//   clk        in   rising-edge clock
//   clr_n      in   asynchronous active-low reset
//   we         in   write enable
//   wsel       in   write address
//   d          in   write data
//   rsel_a     in   read address, port A
//   rsel_b     in   read address, port B
//   q_a        out  registered read data, port A
//   q_b        out  registered read data, port B
//   scrub_req  in   start clearing all entries
//   busy       out  scrub in progress (writes are dropped)
//   scrub_done out  high during the final scrub cycle
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel_a,
    input  logic [AW-1:0]    rsel_b,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    input  logic             scrub_req,
    output logic             busy,
    output logic             scrub_done
);

    // One extra bit so DEPTH itself is representable when DEPTH = 2**AW.
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] q_a_q, q_a_d;
    logic [WIDTH-1:0] q_b_q, q_b_d;

    logic          scrub_we;
    logic [AW-1:0] scrub_idx;
    logic          wr_ok;

    scrub_ctrl #(
        .DEPTH(DEPTH)
    ) u_scrub (
        .clk       (clk),
        .clr_n     (clr_n),
        .scrub_req (scrub_req),
        .busy      (busy),
        .scrub_done(scrub_done),
        .scrub_we  (scrub_we),
        .scrub_idx (scrub_idx)
    );

    // Writes during a scrub are dropped, never stalled.
    assign wr_ok = we && !busy && ({1'b0, wsel} < DEPTH_V)
                   && !((ZERO_R0 != 0) && (wsel == '0));

    // Read resolution in priority order: out of range, hard-wired zero,
    // same-edge write, same-edge scrub clear, stored value.
    function automatic logic [WIDTH-1:0] resolve(
        input logic [AW-1:0]    sel,
        input logic [WIDTH-1:0] stored,
        input logic             w_ok,
        input logic [AW-1:0]    w_sel,
        input logic [WIDTH-1:0] w_data,
        input logic             s_we,
        input logic [AW-1:0]    s_idx
    );
        logic [WIDTH-1:0] r;
        if ({1'b0, sel} >= DEPTH_V) begin
            r = '0;
        end else if ((ZERO_R0 != 0) && (sel == '0)) begin
            r = '0;
        end else if (w_ok && (w_sel == sel)) begin
            r = w_data;
        end else if (s_we && (s_idx == sel)) begin
            r = '0;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Write and scrub can never both target the array in one cycle since
    // wr_ok already requires busy to be low.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (scrub_we && (scrub_idx == AW'(i))) begin
                mem_d[i] = '0;
            end
            if (wr_ok && (wsel == AW'(i))) begin
                mem_d[i] = d;
            end
        end
    end

    always_comb begin
        q_a_d = resolve(rsel_a, mem_q[rsel_a], wr_ok, wsel, d, scrub_we, scrub_idx);
        q_b_d = resolve(rsel_b, mem_q[rsel_b], wr_ok, wsel, d, scrub_we, scrub_idx);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
// Scoreboard bench for two register-file configurations: an 8x8 file with a
// normal entry 0 (dut0), and an 8x6 file with hard-wired zero entry 0 (dut1).
// applyStimulus drives one cycle of inputs and queues the hand-computed
// response for the following edge; an independent monitor pops and compares.
module tb_regfile_param;

    logic clk = 1'b0;
    logic clr_n = 1'b0;

    logic       we0 = 1'b0, req0 = 1'b0;
    logic [2:0] wsel0 = '0, ra0 = '0, rb0 = '0;
    logic [7:0] d0 = '0;
    logic [7:0] q_a0, q_b0;
    logic       busy0, done0;

    logic       we1 = 1'b0, req1 = 1'b0;
    logic [2:0] wsel1 = '0, ra1 = '0, rb1 = '0;
    logic [7:0] d1 = '0;
    logic [7:0] q_a1, q_b1;
    logic       busy1, done1;

    int vec_count  = 0;
    int miss_count = 0;
    int cyc        = 0;

    typedef struct packed {
        logic [31:0] due;
        logic        dut;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        ebusy;
        logic        edone;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_R0(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .we(we0), .wsel(wsel0), .d(d0),
        .rsel_a(ra0), .rsel_b(rb0), .q_a(q_a0), .q_b(q_b0),
        .scrub_req(req0), .busy(busy0), .scrub_done(done0)
    );

    regfile_param #(.WIDTH(8), .DEPTH(6), .ZERO_R0(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .we(we1), .wsel(wsel1), .d(d1),
        .rsel_a(ra1), .rsel_b(rb1), .q_a(q_a1), .q_b(q_b1),
        .scrub_req(req1), .busy(busy1), .scrub_done(done1)
    );

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on the chosen DUT (the other is held idle) and queue
    // the response expected right after the next rising edge.
    task automatic applyStimulus(
        input int dut, input logic w_en, input logic [2:0] w_sel, input logic [7:0] w_data,
        input logic [2:0] sel_a, input logic [2:0] sel_b, input logic req,
        input logic [7:0] exp_a, input logic [7:0] exp_b,
        input logic exp_busy, input logic exp_done, input string name
    );
        exp_t e;
        @(negedge clk);
        if (dut == 0) begin
            we0 = w_en; wsel0 = w_sel; d0 = w_data; ra0 = sel_a; rb0 = sel_b; req0 = req;
            we1 = 1'b0; req1 = 1'b0;
        end else begin
            we1 = w_en; wsel1 = w_sel; d1 = w_data; ra1 = sel_a; rb1 = sel_b; req1 = req;
            we0 = 1'b0; req0 = 1'b0;
        end
        e.due   = 32'(cyc + 1);
        e.dut   = (dut != 0);
        e.ea    = exp_a;
        e.eb    = exp_b;
        e.ebusy = exp_busy;
        e.edone = exp_done;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: after each rising edge, compare every queued expectation
    // that falls due on this edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (!e.dut) begin
                    checkOutput({n, "_qa"}, q_a0, e.ea);
                    checkOutput({n, "_qb"}, q_b0, e.eb);
                    checkOutput({n, "_busy"}, {7'd0, busy0}, {7'd0, e.ebusy});
                    checkOutput({n, "_done"}, {7'd0, done0}, {7'd0, e.edone});
                end else begin
                    checkOutput({n, "_qa"}, q_a1, e.ea);
                    checkOutput({n, "_qb"}, q_b1, e.eb);
                    checkOutput({n, "_busy"}, {7'd0, busy1}, {7'd0, e.ebusy});
                    checkOutput({n, "_done"}, {7'd0, done1}, {7'd0, e.edone});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state while clr_n is still low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_qa0", q_a0, 8'h00);
        checkOutput("rst_busy0", {7'd0, busy0}, 8'h00);
        checkOutput("rst_done0", {7'd0, done0}, 8'h00);
        checkOutput("rst_qb1", q_b1, 8'h00);
        @(negedge clk);
        clr_n = 1'b1;

        // Every address on both ports reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 0, 8'h00, 8'h00, 0, 0, "rst_read0");
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 0, 8'h00, 8'h00, 0, 0, "rst_read1");
        end

        // Basic writes and reads, including bypass on port B.
        applyStimulus(0, 1, 3'd3, 8'hA5, 3'd0, 3'd0, 0, 8'h00, 8'h00, 0, 0, "wr3");
        applyStimulus(0, 1, 3'd7, 8'h3C, 3'd3, 3'd7, 0, 8'hA5, 8'h3C, 0, 0, "wr7_rd");
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd3, 3'd7, 0, 8'hA5, 8'h3C, 0, 0, "rd37");

        // Write-first bypass on port A.
        applyStimulus(0, 1, 3'd5, 8'h77, 3'd5, 3'd3, 0, 8'h77, 8'hA5, 0, 0, "bypass5");
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd5, 3'd5, 0, 8'h77, 8'h77, 0, 0, "rd55");

        // Fill every entry with i*16+1, each visible through the bypass.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 3'(i), 8'(i * 16 + 1), 3'(i), 3'(i), 0,
                          8'(i * 16 + 1), 8'(i * 16 + 1), 0, 0, "fill");
        end
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd6, 0, 8'h21, 8'h61, 0, 0, "rd_fill");

        // Scrub: busy for 8 cycles, done on the 8th, write at j=3 dropped.
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd0, 3'd1, 1, 8'h01, 8'h11, 1, 0, "scrub_start");
        for (int j = 1; j <= 7; j++) begin
            applyStimulus(0, (j == 3), 3'd6, 8'hEE, 3'(j - 1), 3'd7, 0,
                          8'h00, 8'h71, 1, (j == 7), "scrub_run");
        end
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd7, 3'd6, 0, 8'h00, 8'h00, 0, 0, "scrub_end");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 3'd0, 8'h00, 3'(i), 3'(i + 4), 0, 8'h00, 8'h00, 0, 0, "post_scrub");
        end
        applyStimulus(0, 1, 3'd1, 8'h5A, 3'd1, 3'd0, 0, 8'h5A, 8'h00, 0, 0, "wr_after");

        // Reset in the middle of a scrub, with idx = 4.
        applyStimulus(0, 1, 3'd4, 8'h44, 3'd4, 3'd1, 0, 8'h44, 8'h5A, 0, 0, "prep4");
        applyStimulus(0, 1, 3'd2, 8'h22, 3'd2, 3'd4, 0, 8'h22, 8'h44, 0, 0, "prep2");
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd4, 3'd2, 1, 8'h44, 8'h22, 1, 0, "mid_start");
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(0, 0, 3'd0, 8'h00, 3'd4, 3'd1, 0,
                          8'h44, (j >= 2) ? 8'h00 : 8'h5A, 1, 0, "mid_run");
        end
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {7'd0, busy0}, 8'h00);
        checkOutput("midrst_done", {7'd0, done0}, 8'h00);
        checkOutput("midrst_qa", q_a0, 8'h00);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd4, 3'd2, 0, 8'h00, 8'h00, 0, 0, "after_rst");

        // Scrub request together with a write: the write lands, then clears.
        applyStimulus(0, 1, 3'd2, 8'h11, 3'd2, 3'd2, 1, 8'h11, 8'h11, 1, 0, "req_wr");
        for (int j = 1; j <= 7; j++) begin
            applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd4, 0,
                          (j < 3) ? 8'h11 : 8'h00, 8'h00, 1, (j == 7), "req_wr_run");
        end
        applyStimulus(0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 0, 8'h00, 8'h00, 0, 0, "req_wr_end");

        // Hard-wired zero entry and out-of-range addresses on the 6-entry file.
        applyStimulus(1, 1, 3'd0, 8'hFF, 3'd0, 3'd0, 0, 8'h00, 8'h00, 0, 0, "z_wr0");
        applyStimulus(1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 8'h00, 8'h00, 0, 0, "z_rd0");
        applyStimulus(1, 1, 3'd1, 8'h12, 3'd1, 3'd0, 0, 8'h12, 8'h00, 0, 0, "z_wr1");
        applyStimulus(1, 1, 3'd7, 8'hAB, 3'd7, 3'd1, 0, 8'h00, 8'h12, 0, 0, "z_wr7");
        applyStimulus(1, 1, 3'd6, 8'hCD, 3'd6, 3'd1, 0, 8'h00, 8'h12, 0, 0, "z_wr6");
        applyStimulus(1, 0, 3'd0, 8'h00, 3'd6, 3'd7, 0, 8'h00, 8'h00, 0, 0, "z_rd67");
        applyStimulus(1, 0, 3'd0, 8'h00, 3'd1, 3'd1, 0, 8'h12, 8'h12, 0, 0, "z_rd1");

        // Let the monitor drain; anything left over is a lost response.
        @(negedge clk);
        we0 = 1'b0; req0 = 1'b0; we1 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vec_count++;
            miss_count++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
